out_mux_sel_ctrl: RTL and testbench
===================================

// Module: out_mux_sel_ctrl
// PURPOSE
// - Sequences the 16:1 result-readout mux after an NTT frame completes.
// - Walks bank rows 0..ROWS-1. Per row: one read pulse to all 16 banks, then mux selects 0..15.
// - Output is a valid/ready stream, one D_width word per accepted beat.
// - Sits between the bank memories and the host/output interface; drives the mux select and the bank read address.
// PARAMETERS
// - ROWS    16             words per bank (rows per frame); >=1
// - ADDR_W  $clog2(ROWS)   bank row address width; >=1
// - RD_LAT  1              bank read latency in cycles; >=1
// - SEL_W   `pow_radix_k1  select width (localparam from define.svh, =4)
// PORTS
// - clk         in   1       clock
// - rst         in   1       synchronous reset, active-high
// - start       in   1       begin frame readout; sampled in IDLE only
// - busy        out  1       high whenever state != IDLE
// - done        out  1       one-cycle pulse after last beat accepted
// - bank_rd_en  out  1       one-cycle read strobe to all 16 banks
// - bank_addr   out  ADDR_W  row address; valid with bank_rd_en
// - sel_out     out  SEL_W   mux select; stable while out_valid && !out_ready
// - out_valid   out  1       mux output word valid
// - out_ready   in   1       downstream accepts beat when out_valid && out_ready
// - out_last    out  1       out_valid && beat idx==15 && row==ROWS-1
// BEHAVIOUR
// - Reset: state=IDLE, row=0, idx=0, wait cnt=0; all outputs 0.
// - Reset mid-frame: same as reset on next edge; no done pulse.
// - States: IDLE, RD, WAIT, STREAM, DONE.
// - IDLE: on start -> RD.
//   - start while busy is ignored.
// - RD (1 cycle): bank_rd_en=1, bank_addr=row.
//   - RD_LAT==1 -> STREAM; else -> WAIT.
// - WAIT: holds RD_LAT-1 cycles (counter), then -> STREAM.
// - STREAM: out_valid=1, sel_out=order(idx).
//   - On handshake: idx++.
//   - Handshake at idx==15: idx=0. If row==ROWS-1 -> DONE, else row++ and -> RD.
//   - No handshake: idx, sel_out and out_valid all hold.
//   - Banks hold read data until the next bank_rd_en (no re-read required).
// - DONE (1 cycle): done=1, row=0 -> IDLE.
//   - start in the DONE cycle is ignored.
// - Latency: start at cycle T -> bank_rd_en at T+1 -> first out_valid at T+1+RD_LAT.
// - Per-row cost with out_ready=1: RD_LAT+16 cycles.
//   - Frame: ROWS*(RD_LAT+16) cycles, then DONE.
// - Counters: idx is SEL_W bits, wraps 15->0 by design. Row never exceeds ROWS-1.
// CONFIGURATION
// - OUT_BIT_REVERSE_EN defined: order(idx) = bit-reverse of idx over SEL_W bits.
//   - Sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
//   - Undoes the radix-16 digit reversal.
// - Not defined: order(idx) = idx (natural 0..15).
// - out_last and beat counting depend on idx, never on sel_out, in both builds.
// TESTING
// - Reset, idle 5 cycles.
//   -> all outputs 0, busy=0.
// - ROWS=16, RD_LAT=1, out_ready=1, start@T.
//   -> bank_rd_en@T+1 addr0.
//   -> out_valid@T+2 sel 0..15.
//   -> rd_en addr1 @T+18.
//   -> out_last on 256th beat; done 1 cycle later; busy falls with done.
// - RD_LAT=3, out_ready toggled 1/0 every cycle.
//   -> first out_valid 3 cycles after rd_en.
//   -> sel_out stable across stalled cycles.
//   -> exactly 16 accepted beats per row, no skips or duplicates.
// - start pulsed mid-STREAM and in the DONE cycle.
//   -> ignored; row/idx unaffected; no second frame starts.
// - rst asserted at row 5, idx 7.
//   -> next cycle IDLE, outputs 0, no done.
//   -> fresh start restarts at addr0, sel0.
// - OUT_BIT_REVERSE_EN defined, ROWS=2.
//   -> sel_out per row 0,8,4,12,...,7,15.
//   -> out_last with sel_out=15 on beat 32.

Source files
------------

// File: rtl/out_mux_sel_ctrl.sv
// rtl/out_mux_sel_ctrl.sv - result-readout sequencer for the 16:1 bank output mux
// Optional build macro: OUT_BIT_REVERSE_EN (select order is the bit-reverse of the beat index).
module out_mux_sel_ctrl #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bank_rd_en,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [3:0]        sel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int SEL_W = 4;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [SEL_W-1:0]  LAST_IDX = '1;
  localparam logic [CNT_W-1:0]  WAIT_END = CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Select order only; beat counting and out_last always follow idx.
  function automatic logic [SEL_W-1:0] order(input logic [SEL_W-1:0] i);
    logic [SEL_W-1:0] r;
`ifdef OUT_BIT_REVERSE_EN
    for (int b = 0; b < SEL_W; b++) begin
      r[b] = i[SEL_W-1-b];
    end
`else
    r = i;
`endif
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    bank_rd_en = 1'b0;
    bank_addr  = '0;
    sel_out    = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
        end
      end

      S_RD: begin
        bank_rd_en = 1'b1;
        bank_addr  = row_q;
        cnt_d      = '0;
        state_d    = (RD_LAT == 1) ? S_STREAM : S_WAIT;
      end

      // Covers the remaining RD_LAT-1 cycles of bank read latency.
      S_WAIT: begin
        if (cnt_q == WAIT_END) begin
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STREAM: begin
        out_valid = 1'b1;
        sel_out   = order(idx_q);
        out_last  = (idx_q == LAST_IDX) && (row_q == LAST_ROW);
        if (out_ready) begin
          idx_d = idx_q + SEL_W'(1);
          if (idx_q == LAST_IDX) begin
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + ADDR_W'(1);
              state_d = S_RD;
            end
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        row_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_out_mux_sel_ctrl.sv
// tb/tb_out_mux_sel_ctrl.sv - randomized bench for out_mux_sel_ctrl against a beat-count reference model
// Honours OUT_BIT_REVERSE_EN the same way as the design.
module tb_out_mux_sel_ctrl;

  localparam int ROWS_A = 16;
  localparam int LAT_A  = 1;
  localparam int ROWS_B = 3;
  localparam int LAT_B  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, ready_a = 1'b0;
  logic       busy_a, done_a, rd_en_a, valid_a, last_a;
  logic [3:0] addr_a, sel_a;

  logic       start_b = 1'b0, ready_b = 1'b0;
  logic       busy_b, done_b, rd_en_b, valid_b, last_b;
  logic [1:0] addr_b;
  logic [3:0] sel_b;

  out_mux_sel_ctrl #(.ROWS(ROWS_A), .RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .bank_rd_en(rd_en_a), .bank_addr(addr_a), .sel_out(sel_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a)
  );

  out_mux_sel_ctrl #(.ROWS(ROWS_B), .RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .bank_rd_en(rd_en_b), .bank_addr(addr_b), .sel_out(sel_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model per instance: frame active, beats accepted so far, cycles left before data, done pending.
  int m_active[2];
  int m_k[2];
  int m_fetch[2];
  int m_done[2];
  int m_rows[2];
  int m_lat[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_order(input int i);
`ifdef OUT_BIT_REVERSE_EN
    return ((i % 2) * 8) + (((i / 2) % 2) * 4) + (((i / 4) % 2) * 2) + ((i / 8) % 2);
`else
    return i;
`endif
  endfunction

  task automatic check_inst(input int x, input logic [31:0] busy, input logic [31:0] rd_en,
                            input logic [31:0] addr, input logic [31:0] sel,
                            input logic [31:0] valid, input logic [31:0] last,
                            input logic [31:0] dn);
    string nm;
    int e_rd, e_valid;
    nm      = (x == 0) ? "a" : "b";
    e_rd    = (m_active[x] != 0 && m_fetch[x] == m_lat[x]) ? 1 : 0;
    e_valid = (m_active[x] != 0 && m_fetch[x] == 0) ? 1 : 0;
    check_eq({nm, ".busy"}, busy, (m_active[x] != 0 || m_done[x] != 0) ? 1 : 0);
    check_eq({nm, ".rd_en"}, rd_en, e_rd);
    check_eq({nm, ".addr"}, addr, e_rd ? m_k[x] / 16 : 0);
    check_eq({nm, ".valid"}, valid, e_valid);
    check_eq({nm, ".sel"}, sel, e_valid ? exp_order(m_k[x] % 16) : 0);
    check_eq({nm, ".last"}, last, (e_valid && m_k[x] == m_rows[x] * 16 - 1) ? 1 : 0);
    check_eq({nm, ".done"}, dn, m_done[x]);
  endtask

  task automatic model_update(input int x, input logic st, input logic rdy);
    if (rst) begin
      m_active[x] = 0; m_k[x] = 0; m_fetch[x] = 0; m_done[x] = 0;
    end else if (m_done[x] != 0) begin
      m_done[x] = 0;
    end else if (m_active[x] != 0) begin
      if (m_fetch[x] > 0) begin
        m_fetch[x]--;
      end else if (rdy) begin
        m_k[x]++;
        if (m_k[x] == m_rows[x] * 16) begin
          m_active[x] = 0;
          m_done[x]   = 1;
        end else if (m_k[x] % 16 == 0) begin
          m_fetch[x] = m_lat[x];
        end
      end
    end else if (st) begin
      m_active[x] = 1; m_k[x] = 0; m_fetch[x] = m_lat[x];
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_inst(0, 32'(busy_a), 32'(rd_en_a), 32'(addr_a), 32'(sel_a), 32'(valid_a), 32'(last_a), 32'(done_a));
    check_inst(1, 32'(busy_b), 32'(rd_en_b), 32'(addr_b), 32'(sel_b), 32'(valid_b), 32'(last_b), 32'(done_b));
    model_update(0, start_a, ready_a);
    model_update(1, start_b, ready_b);
    @(posedge clk);
    #1;
  endtask

  function automatic logic idle_both();
    return (m_active[0] == 0 && m_done[0] == 0 && m_active[1] == 0 && m_done[1] == 0);
  endfunction

  initial begin
    int n;
    for (int x = 0; x < 2; x++) begin
      m_active[x] = 0; m_k[x] = 0; m_fetch[x] = 0; m_done[x] = 0;
    end
    m_rows[0] = ROWS_A; m_lat[0] = LAT_A;
    m_rows[1] = ROWS_B; m_lat[1] = LAT_B;

    // Reset, then idle with no start.
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Full frames: A with ready held high, B with ready toggling; start poked while busy and in DONE.
    start_a = 1'b1; start_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    step();
    n = 0;
    while (!idle_both() && n < 2000) begin
      start_a = (m_done[0] != 0) || (m_active[0] != 0 && $urandom_range(0, 7) == 0);
      start_b = (m_done[1] != 0) || (m_active[1] != 0 && $urandom_range(0, 7) == 0);
      ready_b = ~ready_b;
      step();
      n++;
    end
    check_eq("frame_timeout", 32'(n < 2000), 1);
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Fully random traffic including occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 499) == 0);
      start_a = ($urandom_range(0, 15) == 0);
      start_b = ($urandom_range(0, 15) == 0);
      ready_a = ($urandom_range(0, 3) != 0);
      ready_b = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset while presenting row 5 beat 7, then restart cleanly.
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    step();
    rst = 1'b0; ready_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (!(m_active[0] != 0 && m_fetch[0] == 0 && m_k[0] == 5 * 16 + 7) && n < 300) begin
      step();
      n++;
    end
    check_eq("row5_timeout", 32'(n < 300), 1);
    check_eq("row5_sel", 32'(sel_a), exp_order(7));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
